// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, ALU operations, the control bundle and
// the instruction field layout used by decode_stage.
package decode_pkg;

    localparam int INSTR_W   = 32;
    localparam int OPCODE_W  = 5;
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 27;
    localparam int RD_HI     = 26;
    localparam int IMM_W     = 16;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    typedef enum logic [OPCODE_W-1:0] {
        OP_LDM = 5'b00001,
        OP_STD = 5'b00010,
        OP_ADD = 5'b00011,
        OP_NOT = 5'b00100,
        OP_NOP = 5'b00101
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_NOT = 3'b001,
        ALU_LDM = 3'b010,
        ALU_STD = 3'b011,
        ALU_NOP = 3'b100
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    alu_source;
        logic    mem_to_reg;
        alu_op_e alu_control;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        mem_read:    1'b0,
        alu_source:  1'b0,
        mem_to_reg:  1'b0,
        alu_control: ALU_NOP,
        illegal:     1'b0
    };

    // Register fields (rd, rs1, rs2) sit back to back below the opcode.
    function automatic int field_hi(input int addr_w, input int index);
        return RD_HI - index * addr_w;
    endfunction

    function automatic ctrl_t decode_opcode(input opcode_e opcode);
        ctrl_t c;
        c = CTRL_NOP;
        case (opcode)
            OP_LDM: begin
                c.reg_write   = 1'b1;
                c.mem_read    = 1'b1;
                c.alu_source  = 1'b1;
                c.mem_to_reg  = 1'b1;
                c.alu_control = ALU_LDM;
            end
            OP_STD: begin
                c.mem_write   = 1'b1;
                c.alu_control = ALU_STD;
            end
            OP_ADD: begin
                c.reg_write   = 1'b1;
                c.alu_control = ALU_ADD;
            end
            OP_NOT: begin
                c.reg_write   = 1'b1;
                c.alu_control = ALU_NOT;
            end
            OP_NOP: begin
                c.alu_control = ALU_NOP;
            end
            default: begin
                c.illegal = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file: one synchronous write port and two combinational
// read ports that forward a same-cycle write to the reader.
module regfile_bypass #(
    parameter int  DATA_W    = 16,
    parameter int  REG_COUNT = 8,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] regs_reg [REG_COUNT];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wr_en) begin
            regs_reg[wr_addr] <= wr_data;
        end
    end

    assign raddr[0] = rd_addr1;
    assign raddr[1] = rd_addr2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_read
        assign rdata[gi] = (wr_en && wr_addr == raddr[gi]) ? wr_data : regs_reg[raddr[gi]];
    end

    assign rd_data1 = rdata[0];
    assign rd_data2 = rdata[1];

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: register read with bypass, opcode decode, load-use
// scoreboard and a registered ID/EX slot with valid/ready handshakes.
module decode_stage
    import decode_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  REG_COUNT = 8,
    localparam int ADDR_W    = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_is_load,
    output logic              REG_Write,
    output logic              MEM_Write,
    output logic              MEM_Read,
    output logic              ALU_Source,
    output logic              MEM_to_REG,
    output logic [2:0]        ALU_Control,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] imm,
    output logic              illegal
);

    localparam int RS1_HI = field_hi(ADDR_W, 1);
    localparam int RS2_HI = field_hi(ADDR_W, 2);

    logic [ADDR_W-1:0]       rd_field;
    logic [ADDR_W-1:0]       rs1_field;
    logic [ADDR_W-1:0]       rs2_field;
    logic signed [IMM_W-1:0] imm_field;
    logic [DATA_W-1:0]       imm_ext;
    logic [DATA_W-1:0]       rs1_data;
    logic [DATA_W-1:0]       rs2_data;
    ctrl_t                   ctrl_dec;
    logic                    unused_instr;

    logic                    out_valid_reg;
    ctrl_t                   ctrl_reg;
    logic [ADDR_W-1:0]       rd_addr_reg;
    logic [DATA_W-1:0]       read_data1_reg;
    logic [DATA_W-1:0]       read_data2_reg;
    logic [DATA_W-1:0]       imm_reg;

    logic [REG_COUNT-1:0]    busy_reg;
    logic [REG_COUNT-1:0]    busy_next;
    logic                    ldm_in_idex_hit;
    logic                    stall;
    logic                    accept;
    logic                    ldm_leaving;

    assign rd_field     = instr[RD_HI -: ADDR_W];
    assign rs1_field    = instr[RS1_HI -: ADDR_W];
    assign rs2_field    = instr[RS2_HI -: ADDR_W];
    assign imm_field    = instr[IMM_HI:IMM_LO];
    assign imm_ext      = DATA_W'(imm_field);
    assign unused_instr = ^instr;

    assign ctrl_dec = decode_opcode(opcode_e'(instr[OPCODE_HI:OPCODE_LO]));

    regfile_bypass #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data),
        .rd_addr1 (rs1_field),
        .rd_data1 (rs1_data),
        .rd_addr2 (rs2_field),
        .rd_data2 (rs2_data)
    );

    // A load still sitting in ID/EX has not set its busy bit yet, so match it directly.
    assign ldm_in_idex_hit = out_valid_reg && ctrl_reg.mem_read &&
                             (rs1_field == rd_addr_reg || rs2_field == rd_addr_reg);
    assign stall    = in_valid && (busy_reg[rs1_field] || busy_reg[rs2_field] || ldm_in_idex_hit);
    assign in_ready = reset && !flush && !stall && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;

    assign ldm_leaving = out_valid_reg && out_ready && ctrl_reg.mem_read;

    // Set is applied after clear so a load leaving decode wins over a same-register completion.
    always_comb begin
        busy_next = busy_reg;
        if (wb_en && wb_is_load) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (ldm_leaving) begin
            busy_next[rd_addr_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg  <= 1'b0;
            ctrl_reg       <= '0;
            rd_addr_reg    <= '0;
            read_data1_reg <= '0;
            read_data2_reg <= '0;
            imm_reg        <= '0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            ctrl_reg       <= ctrl_dec;
            rd_addr_reg    <= rd_field;
            read_data1_reg <= rs1_data;
            read_data2_reg <= rs2_data;
            imm_reg        <= imm_ext;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid   = out_valid_reg;
    assign REG_Write   = ctrl_reg.reg_write;
    assign MEM_Write   = ctrl_reg.mem_write;
    assign MEM_Read    = ctrl_reg.mem_read;
    assign ALU_Source  = ctrl_reg.alu_source;
    assign MEM_to_REG  = ctrl_reg.mem_to_reg;
    assign ALU_Control = ctrl_reg.alu_control;
    assign illegal     = ctrl_reg.illegal;
    assign rd_addr     = rd_addr_reg;
    assign read_data1  = read_data1_reg;
    assign read_data2  = read_data2_reg;
    assign imm         = imm_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table, hand-written reset sequence and
// randomized traffic checked against a cycle-level reference model.
module tb_decode_stage;

    localparam int DATA_W    = 32;
    localparam int REG_COUNT = 8;
    localparam int ADDR_W    = 3;
    localparam int NV        = 21;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic              out_valid;
    logic              out_ready;
    logic              flush;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_is_load;
    logic              REG_Write;
    logic              MEM_Write;
    logic              MEM_Read;
    logic              ALU_Source;
    logic              MEM_to_REG;
    logic [2:0]        ALU_Control;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] imm;
    logic              illegal;
    logic [8:0]        ctrl_bus;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctrl_bus = {illegal, REG_Write, MEM_Write, MEM_Read, ALU_Source, MEM_to_REG, ALU_Control};

    decode_stage #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .flush       (flush),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_is_load  (wb_is_load),
        .REG_Write   (REG_Write),
        .MEM_Write   (MEM_Write),
        .MEM_Read    (MEM_Read),
        .ALU_Source  (ALU_Source),
        .MEM_to_REG  (MEM_to_REG),
        .ALU_Control (ALU_Control),
        .rd_addr     (rd_addr),
        .read_data1  (read_data1),
        .read_data2  (read_data2),
        .imm         (imm),
        .illegal     (illegal)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] ins;
        logic        ordy;
        logic        fl;
        logic        wbe;
        logic [2:0]  wba;
        logic [31:0] wbd;
        logic        wbl;
        logic        e_rdy;
        logic        e_ov;
        logic        chk;
        logic [8:0]  e_ctrl;
        logic [2:0]  e_rd;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [31:0] e_imm;
    } vec_t;

    vec_t vecs [NV];

    // Expected {illegal, REG_Write, MEM_Write, MEM_Read, ALU_Source, MEM_to_REG, ALU_Control}.
    function automatic logic [8:0] ref_ctrl(input logic [4:0] op);
        case (op)
            5'd1:    return 9'h0BA;
            5'd2:    return 9'h043;
            5'd3:    return 9'h080;
            5'd4:    return 9'h081;
            5'd5:    return 9'h004;
            default: return 9'h104;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] im);
        return {op, rd, rs1, rs2, 2'b00, im};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic ordy, input logic fl,
                         input logic wbe, input logic [2:0] wba, input logic [31:0] wbd,
                         input logic wbl);
        in_valid   = iv;
        instr      = ins;
        out_ready  = ordy;
        flush      = fl;
        wb_en      = wbe;
        wb_addr    = wba;
        wb_data    = wbd;
        wb_is_load = wbl;
    endtask

    task automatic check_fields(input string tag, input logic [8:0] e_ctrl, input logic [2:0] e_rd,
                                input logic [31:0] e_d1, input logic [31:0] e_d2,
                                input logic [31:0] e_imm);
        check({tag, ".ctrl"}, 32'(ctrl_bus), 32'(e_ctrl));
        check({tag, ".rd_addr"}, 32'(rd_addr), 32'(e_rd));
        check({tag, ".read_data1"}, read_data1, e_d1);
        check({tag, ".read_data2"}, read_data2, e_d2);
        check({tag, ".imm"}, imm, e_imm);
    endtask

    // Reference model state
    logic [31:0] m_rf [REG_COUNT];
    logic        m_busy [REG_COUNT];
    logic        m_v;
    logic [8:0]  m_ctrl;
    logic [2:0]  m_rd;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    logic [31:0] m_imm;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        string tag;
        vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd1, 32'd5, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{1'b1, mk(5'd3, 3'd3, 3'd1, 3'd2, 16'h0010), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h080, 3'd3, 32'd5, 32'd7, 32'h10};
        vecs[3]  = '{1'b1, mk(5'd3, 3'd5, 3'd4, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b1, 3'd4, 32'h00AB, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h080, 3'd5, 32'h00AB, 32'd5, 32'h0};
        vecs[4]  = '{1'b1, mk(5'd1, 3'd2, 3'd0, 3'd0, 16'h0004), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h0BA, 3'd2, 32'h0, 32'h0, 32'h4};
        vecs[5]  = '{1'b1, mk(5'd3, 3'd6, 3'd2, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = vecs[5];
        vecs[7]  = '{1'b1, mk(5'd3, 3'd6, 3'd2, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b1, 3'd2, 32'h1234, 1'b1,
                     1'b0, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[8]  = '{1'b1, mk(5'd3, 3'd6, 3'd2, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h080, 3'd6, 32'h1234, 32'd5, 32'h0};
        vecs[9]  = '{1'b1, mk(5'd4, 3'd7, 3'd1, 3'd4, 16'h0000), 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b0, 1'b1, 1'b1, 9'h080, 3'd6, 32'h1234, 32'd5, 32'h0};
        vecs[10] = vecs[9];
        vecs[11] = vecs[9];
        vecs[12] = '{1'b1, mk(5'd4, 3'd7, 3'd1, 3'd4, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h081, 3'd7, 32'd5, 32'h00AB, 32'h0};
        vecs[13] = '{1'b1, mk(5'd1, 3'd5, 3'd0, 3'd0, 16'hFFFE), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h0BA, 3'd5, 32'h0, 32'h0, 32'hFFFF_FFFE};
        vecs[14] = '{1'b1, mk(5'd2, 3'd0, 3'd1, 3'd2, 16'h0008), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h043, 3'd0, 32'd5, 32'h1234, 32'h8};
        vecs[15] = '{1'b1, mk(5'd3, 3'd1, 3'd1, 3'd1, 16'h0000), 1'b1, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[16] = '{1'b1, mk(5'd3, 3'd1, 3'd5, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b0, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[17] = '{1'b1, mk(5'd3, 3'd1, 3'd5, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b1, 3'd5, 32'h55, 1'b1,
                     1'b0, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};
        vecs[18] = '{1'b1, mk(5'd3, 3'd1, 3'd5, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h080, 3'd1, 32'h55, 32'd5, 32'h0};
        vecs[19] = '{1'b1, mk(5'b11111, 3'd0, 3'd0, 3'd0, 16'h8000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0,
                     1'b1, 1'b1, 1'b1, 9'h104, 3'd0, 32'h0, 32'h0, 32'hFFFF_8000};
        vecs[20] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 9'h0, 3'd0, 32'h0, 32'h0, 32'h0};

        // Reset state: in_valid/out_ready high must still give in_ready=0.
        reset = 1'b0;
        drive(1'b1, mk(5'd3, 3'd1, 3'd2, 3'd3, 16'h1111), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset.in_ready", 32'(in_ready), 32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check_fields("reset", 9'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        $display("reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].iv, vecs[i].ins, vecs[i].ordy, vecs[i].fl,
                  vecs[i].wbe, vecs[i].wba, vecs[i].wbd, vecs[i].wbl);
            #4;
            check({tag, ".in_ready"}, 32'(in_ready), 32'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            check({tag, ".out_valid"}, 32'(out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].chk) begin
                check_fields(tag, vecs[i].e_ctrl, vecs[i].e_rd, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_imm);
            end
            $display("%s: instr=%h in_ready=%0b out_valid=%0b rd1=%h rd2=%h imm=%h",
                     tag, vecs[i].ins, in_ready, out_valid, read_data1, read_data2, imm);
        end

        // Reset asserted while a load-use stall is pending.
        drive(1'b1, mk(5'd1, 3'd3, 3'd0, 3'd0, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("mid.ldm_out_valid", 32'(out_valid), 32'd1);
        drive(1'b1, mk(5'd3, 3'd4, 3'd3, 3'd1, 16'h0000), 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        #4;
        check("mid.stall_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid.reset_in_ready", 32'(in_ready), 32'd0);
        check("mid.reset_out_valid", 32'(out_valid), 32'd0);
        check_fields("mid.reset", 9'h0, 3'd0, 32'h0, 32'h0, 32'h0);
        $display("mid-stall reset: in_ready=%0b out_valid=%0b", in_ready, out_valid);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #3;
        check("mid.after_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("mid.after_out_valid", 32'(out_valid), 32'd1);
        check_fields("mid.after", 9'h080, 3'd4, 32'h0, 32'h0, 32'h0);
        $display("post-reset accept: rd1=%h rd2=%h", read_data1, read_data2);

        // Randomized traffic against the reference model, from a fresh reset.
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int r = 0; r < REG_COUNT; r++) begin
            m_rf[r]   = 32'h0;
            m_busy[r] = 1'b0;
        end
        m_v = 1'b0;
        m_ctrl = 9'h0;
        m_rd = 3'd0;
        m_d1 = 32'h0;
        m_d2 = 32'h0;
        m_imm = 32'h0;

        for (int c = 0; c < 400; c++) begin
            logic        iv, ordy, fl, wbe, wbl, hit, exp_rdy, acc, leave_ldm;
            logic [4:0]  op;
            logic [2:0]  rd, rs1, rs2, wba;
            logic [15:0] im;
            logic [31:0] wbd, ins, d1, d2;
            int unsigned sel;

            sel  = $urandom_range(0, 9);
            op   = (sel < 8) ? 5'(1 + sel % 5) : 5'($urandom_range(0, 31));
            rd   = 3'($urandom_range(0, 7));
            rs1  = 3'($urandom_range(0, 7));
            rs2  = 3'($urandom_range(0, 7));
            im   = 16'($urandom);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 15) == 0);
            wbe  = ($urandom_range(0, 2) == 0);
            wba  = 3'($urandom_range(0, 7));
            wbd  = $urandom;
            wbl  = ($urandom_range(0, 1) == 1);
            ins  = mk(op, rd, rs1, rs2, im);
            drive(iv, ins, ordy, fl, wbe, wba, wbd, wbl);

            hit     = m_v && m_ctrl[5] && (rs1 == m_rd || rs2 == m_rd);
            exp_rdy = !fl && !(iv && (m_busy[rs1] || m_busy[rs2] || hit)) && (!m_v || ordy);
            #4;
            check($sformatf("rnd%0d.in_ready", c), 32'(in_ready), 32'(exp_rdy));
            @(posedge clk);
            #1;

            acc       = iv && exp_rdy;
            leave_ldm = m_v && ordy && m_ctrl[5];
            d1        = (wbe && wba == rs1) ? wbd : m_rf[rs1];
            d2        = (wbe && wba == rs2) ? wbd : m_rf[rs2];
            if (wbe && wbl) m_busy[wba] = 1'b0;
            if (leave_ldm) m_busy[m_rd] = 1'b1;
            if (fl) begin
                m_v = 1'b0;
            end else if (acc) begin
                m_v    = 1'b1;
                m_ctrl = ref_ctrl(op);
                m_rd   = rd;
                m_d1   = d1;
                m_d2   = d2;
                m_imm  = {{16{im[15]}}, im};
            end else if (ordy) begin
                m_v = 1'b0;
            end
            if (wbe) m_rf[wba] = wbd;

            check($sformatf("rnd%0d.out_valid", c), 32'(out_valid), 32'(m_v));
            if (m_v) begin
                check_fields($sformatf("rnd%0d", c), m_ctrl, m_rd, m_d1, m_d2, m_imm);
            end
            if (acc) begin
                $display("rnd%0d: accepted instr=%h rd1=%h rd2=%h", c, ins, read_data1, read_data2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
